// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART rate-select encodings and divisor helper
package uart_pkg;

  localparam int unsigned OVERSAMPLE_DEF = 16;

  localparam logic [1:0] BAUD_SEL_9600   = 2'd0;
  localparam logic [1:0] BAUD_SEL_19200  = 2'd1;
  localparam logic [1:0] BAUD_SEL_57600  = 2'd2;
  localparam logic [1:0] BAUD_SEL_115200 = 2'd3;

  // Clocks per oversample slot, rounded to nearest.
  function automatic longint unsigned calc_div(
    input longint unsigned clk_freq,
    input longint unsigned baud,
    input longint unsigned os
  );
    return (clk_freq + (baud * os) / 2) / (baud * os);
  endfunction

endpackage

// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - wrap-around counter with runtime terminal value, clear and enable
module mod_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] last_val,
  output logic [W-1:0] count,
  output logic         tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tc    = (cnt_q == last_val);
  assign count = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tc ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/baud_tick_gen.sv
// rtl/baud_tick_gen.sv - runtime-selectable baud tick generator (oversample, mid-bit and bit ticks)
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int unsigned BAUD0      = 9600,
  parameter int unsigned BAUD1      = 19200,
  parameter int unsigned BAUD2      = 57600,
  parameter int unsigned BAUD3      = 115200,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [1:0]                    baud_sel,
  input  logic                          resync,
  output logic                          os_tick,
  output logic                          bit_tick,
  output logic                          mid_tick,
  output logic [$clog2(OVERSAMPLE)-1:0] os_idx
);

  localparam int unsigned OS_W = $clog2(OVERSAMPLE);
  localparam longint unsigned DIV0 = calc_div(64'(CLK_FREQ), 64'(BAUD0), 64'(OVERSAMPLE));
  localparam longint unsigned DIV1 = calc_div(64'(CLK_FREQ), 64'(BAUD1), 64'(OVERSAMPLE));
  localparam longint unsigned DIV2 = calc_div(64'(CLK_FREQ), 64'(BAUD2), 64'(OVERSAMPLE));
  localparam longint unsigned DIV3 = calc_div(64'(CLK_FREQ), 64'(BAUD3), 64'(OVERSAMPLE));
  localparam longint unsigned DIV_MAX = (64'd1 << CNT_W) - 64'd1;

  if (DIV0 < 2 || DIV0 > DIV_MAX || DIV1 < 2 || DIV1 > DIV_MAX ||
      DIV2 < 2 || DIV2 > DIV_MAX || DIV3 < 2 || DIV3 > DIV_MAX) begin : g_bad_div
    $error("baud_tick_gen: a baud divisor does not fit the prescaler");
  end
  if (OVERSAMPLE < 4 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_bad_os
    $error("baud_tick_gen: OVERSAMPLE must be a power of two >= 4");
  end

  logic [CNT_W-1:0] div_sel;
  logic [CNT_W-1:0] div_q, div_d;
  logic             enable_q;
  logic             os_tick_q, os_tick_d;
  logic             mid_tick_q, mid_tick_d;
  logic             bit_tick_q, bit_tick_d;
  logic             restart, cnt_clr;
  logic             pre_tc, os_at_last;
  logic [CNT_W-1:0] pre_cnt_unused;
  logic [OS_W-1:0]  os_cnt;

  always_comb begin
    div_sel = CNT_W'(DIV3);
    case (baud_sel)
      BAUD_SEL_9600:   div_sel = CNT_W'(DIV0);
      BAUD_SEL_19200:  div_sel = CNT_W'(DIV1);
      BAUD_SEL_57600:  div_sel = CNT_W'(DIV2);
      BAUD_SEL_115200: div_sel = CNT_W'(DIV3);
    endcase
  end

  // A restart (resync or enable rising) realigns the bit phase and swallows any tick due now.
  assign restart = resync || (enable && !enable_q);
  assign cnt_clr = !enable || restart;

  mod_counter #(.W(CNT_W)) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .en       (1'b1),
    .last_val (div_q - CNT_W'(1)),
    .count    (pre_cnt_unused),
    .tc       (pre_tc)
  );

  // Slot index advances on the registered tick, so os_idx still shows the slot a tick closes.
  mod_counter #(.W(OS_W)) u_os_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .en       (os_tick_q),
    .last_val (OS_W'(OVERSAMPLE - 1)),
    .count    (os_cnt),
    .tc       (os_at_last)
  );

  always_comb begin
    div_d      = div_q;
    os_tick_d  = 1'b0;
    mid_tick_d = 1'b0;
    bit_tick_d = 1'b0;
    if (cnt_clr) begin
      div_d = div_sel;
    end else if (pre_tc) begin
      os_tick_d  = 1'b1;
      mid_tick_d = (os_cnt == OS_W'(OVERSAMPLE / 2 - 1));
      bit_tick_d = os_at_last;
      // Rate changes only land on a bit boundary so the current bit keeps its width.
      if (os_at_last) begin
        div_d = div_sel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q      <= CNT_W'(DIV0);
      enable_q   <= 1'b0;
      os_tick_q  <= 1'b0;
      mid_tick_q <= 1'b0;
      bit_tick_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      enable_q   <= enable;
      os_tick_q  <= os_tick_d;
      mid_tick_q <= mid_tick_d;
      bit_tick_q <= bit_tick_d;
    end
  end

  assign os_tick  = os_tick_q;
  assign mid_tick = mid_tick_q;
  assign bit_tick = bit_tick_q;
  assign os_idx   = os_cnt;

endmodule

// File: tb/tb_baud_tick_gen.sv
// tb/tb_baud_tick_gen.sv - scoreboard bench for baud_tick_gen
module tb_baud_tick_gen;

  localparam int DIV_9600   = 326;
  localparam int DIV_19200  = 163;
  localparam int DIV_115200 = 27;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b1;
  logic       resync = 1'b0;
  logic [1:0] baud_sel = 2'd0;
  logic       os_tick, bit_tick, mid_tick;
  logic [3:0] os_idx;

  typedef struct {
    int cyc;
    bit mid;
    bit bt;
    int idx;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  baud_tick_gen dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .baud_sel (baud_sel),
    .resync   (resync),
    .os_tick  (os_tick),
    .bit_tick (bit_tick),
    .mid_tick (mid_tick),
    .os_idx   (os_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: every output pulse must match the next expected tick.
  always @(negedge clk) begin
    exp_t e;
    if (os_tick || mid_tick || bit_tick) begin
      if (q.size() == 0) begin
        check("unexpected_tick", 1, 0);
      end else begin
        e = q.pop_front();
        check("tick_cycle", cyc, e.cyc);
        check("tick_os", int'(os_tick), 1);
        check("tick_mid", int'(mid_tick), int'(e.mid));
        check("tick_bit", int'(bit_tick), int'(e.bt));
        check("tick_idx", int'(os_idx), e.idx);
      end
    end
  end

  task automatic push_ticks(input int t0, input int n, input int da, input int db);
    int t = t0;
    for (int k = 1; k <= n; k++) begin
      exp_t e;
      t += (k <= 16) ? da : db;
      e.cyc = t;
      e.mid = (k % 16 == 8);
      e.bt  = (k % 16 == 0);
      e.idx = (k - 1) % 16;
      q.push_back(e);
    end
  endtask

  task automatic wait_until(input int x);
    while (cyc < x) @(negedge clk);
    #1;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(name, q.size(), 0);
    if (q.size() != 0) q.delete();
  endtask

  task automatic do_resync(output int t);
    resync = 1'b1;
    t = cyc + 1;
    @(negedge clk);
    #1;
    resync = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_os_tick"}, int'(os_tick), 0);
    check({tag, "_mid_tick"}, int'(mid_tick), 0);
    check({tag, "_bit_tick"}, int'(bit_tick), 0);
    check({tag, "_os_idx"}, int'(os_idx), 0);
  endtask

  initial begin
    int t;

    repeat (3) @(negedge clk);
    #1;
    check_idle("reset");

    rst_n = 1'b1;
    t = cyc + 1;
    push_ticks(t, 17, DIV_9600, DIV_9600);
    wait_until(t + 5616);
    check("pre_reset_queue", q.size(), 0);
    check("pre_reset_idx", int'(os_idx), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check_idle("async_reset");

    baud_sel = 2'd3;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    t = cyc + 1;
    push_ticks(t, 40, DIV_115200, DIV_115200);
    wait_drain(2000, "fast_rate_drain");

    baud_sel = 2'd0;
    do_resync(t);
    push_ticks(t, 36, DIV_9600, DIV_115200);
    wait_until(t + 4 * DIV_9600 + 1);
    check("rate_change_idx", int'(os_idx), 4);
    baud_sel = 2'd3;
    wait_drain(7000, "rate_change_drain");

    baud_sel = 2'd0;
    do_resync(t);
    push_ticks(t, 2, DIV_9600, DIV_9600);
    wait_until(t + 3 * DIV_9600 - 1);
    resync = 1'b1;
    t = cyc + 1;
    @(negedge clk);
    #1;
    resync = 1'b0;
    push_ticks(t, 3, DIV_9600, DIV_9600);
    wait_drain(1500, "resync_tc_drain");

    do_resync(t);
    push_ticks(t, 9, DIV_9600, DIV_9600);
    wait_drain(3500, "pre_disable_drain");
    @(negedge clk);
    #1;
    check("idx_before_disable", int'(os_idx), 9);
    enable = 1'b0;
    @(negedge clk);
    #1;
    check_idle("disable");
    repeat (20) @(negedge clk);
    #1;
    baud_sel = 2'd1;
    enable = 1'b1;
    t = cyc + 1;
    push_ticks(t, 17, DIV_19200, DIV_19200);
    wait_drain(3500, "reenable_drain");

    baud_sel = 2'd0;
    repeat (30) begin
      resync = 1'b1;
      @(negedge clk);
      #1;
      resync = 1'b0;
      repeat (99) @(negedge clk);
      #1;
    end
    check("resync_storm_idx", int'(os_idx), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
